udp_tx_framer: RTL and testbench

- Transmit-side framing stage that directly feeds udp_receiver's 64-bit input bus.
- Accepts one 64-bit payload word plus source/destination ports per packet.
- Computes the 16-bit ones'-complement checksum and emits a 3-word frame: header, checksum word, payload.
- Provides valid/ready backpressure on both sides and a wrapping transmitted-frame counter.

---
 rtl/udp_tx_framer.sv | 138 +++++++++++++
 tb/tb_udp_tx_framer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: captures ports plus one payload word, computes the
// ones'-complement checksum and emits a header / checksum / payload frame.
module udp_tx_framer #(
    parameter logic [15:0] UDP_LEN   = 16'h000A,
    parameter logic [15:0] FRAME_TAG = 16'h0003,
    parameter logic [7:0]  TTL       = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [63:0] in_payload,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] tx_count
);

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        FOLD,
        HDR,
        CSUM,
        PAY
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        running;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [63:0] payload_q;
    logic [19:0] sum_q;
    logic [15:0] csum_q;
    logic [15:0] count_q;
    logic        accept;
    logic        xfer;
    logic [19:0] sum_c;
    logic [16:0] s1;
    logic [15:0] s2;
    logic [15:0] csum_c;

    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign tx_count = count_q;

    // Nine halfwords summed at full width; the carries are folded back in FOLD.
    assign sum_c = 20'(src_q) + 20'(dst_q) + 20'(UDP_LEN) + 20'(FRAME_TAG)
                 + 20'({8'h00, TTL})
                 + 20'(payload_q[63:48]) + 20'(payload_q[47:32])
                 + 20'(payload_q[31:16]) + 20'(payload_q[15:0]);

    assign s1     = {1'b0, sum_q[15:0]} + 17'(sum_q[19:16]);
    assign s2     = s1[15:0] + 16'(s1[16]);
    assign csum_c = ~s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            running   <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            payload_q <= '0;
            sum_q     <= '0;
            csum_q    <= '0;
            count_q   <= '0;
        end else begin
            running <= 1'b1;
            if (accept) begin
                src_q     <= src_port;
                dst_q     <= dst_port;
                payload_q <= in_payload;
            end
            if (state == SUM) begin
                sum_q <= sum_c;
            end
            // An all-zero checksum means "none" to the receiver, so send 0xFFFF.
            if (state == FOLD) begin
                csum_q <= (csum_c == 16'h0000) ? 16'hFFFF : csum_c;
            end
            if (state == PAY && xfer) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SUM;
            SUM:     next_state = FOLD;
            FOLD:    next_state = HDR;
            HDR:     if (xfer) next_state = CSUM;
            CSUM:    if (xfer) next_state = PAY;
            PAY:     if (xfer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: in_ready = running;
            HDR: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_data  = {src_q, dst_q, UDP_LEN, FRAME_TAG};
            end
            CSUM: begin
                out_valid = 1'b1;
                out_data  = {32'h0, 8'h00, TTL, csum_q};
            end
            PAY: begin
                out_valid = 1'b1;
                out_eop   = 1'b1;
                out_data  = payload_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed plus randomized bench for udp_tx_framer, checked against a
// ones'-complement reference model computed from the frame definition.
module tb_udp_tx_framer;

    localparam logic [15:0] UDP_LEN   = 16'h000A;
    localparam logic [15:0] FRAME_TAG = 16'h0003;
    localparam logic [7:0]  TTL       = 8'h40;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [63:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] tx_count;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          acceptCycle = 0;
    logic [15:0] modelCount = 16'h0000;

    udp_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src_port   (src_port),
        .dst_port   (dst_port),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .tx_count   (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // End-around-carry accumulation: any carry out of bit 15 re-enters at bit 0.
    function automatic logic [15:0] refChecksum(input logic [15:0] s, input logic [15:0] d,
                                                input logic [63:0] p);
        logic [15:0] hw [9];
        int unsigned acc;
        logic [15:0] res;
        hw = '{s, d, UDP_LEN, FRAME_TAG, {8'h00, TTL}, p[63:48], p[47:32], p[31:16], p[15:0]};
        acc = 0;
        foreach (hw[i]) begin
            acc = acc + 32'(hw[i]);
            if (acc > 32'h0000FFFF) acc = acc - 32'h0000FFFF;
        end
        res = ~acc[15:0];
        return (res == 16'h0000) ? 16'hFFFF : res;
    endfunction

    function automatic logic [63:0] refWord(input int w, input logic [15:0] s, input logic [15:0] d,
                                            input logic [63:0] p);
        case (w)
            0:       return {s, d, UDP_LEN, FRAME_TAG};
            1:       return {32'h0, 8'h00, TTL, refChecksum(s, d, p)};
            default: return p;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [63:0] p,
                                 input bit holdValid);
        int budget;
        budget     = 0;
        src_port   = s;
        dst_port   = d;
        in_payload = p;
        in_valid   = 1'b1;
        while (in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("accept_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acceptCycle = cyc;
        if (!holdValid) in_valid = 1'b0;
        src_port   = 16'($urandom);
        dst_port   = 16'($urandom);
        in_payload = {$urandom, $urandom};
    endtask

    task automatic collectFrame(input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                                input int stallWord, input int stallLen);
        logic [63:0] expWords [3];
        int budget;
        expWords[0] = e0;
        expWords[1] = e1;
        expWords[2] = e2;
        for (int w = 0; w < 3; w++) begin
            budget = 0;
            while (out_valid !== 1'b1 && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            checkOutput("word_valid", 64'(out_valid), 64'd1);
            if (w == stallWord) begin
                out_ready = 1'b0;
                for (int k = 0; k < stallLen; k++) begin
                    @(negedge clk);
                    checkOutput("stall_data", out_data, expWords[w]);
                    checkOutput("stall_valid", 64'(out_valid), 64'd1);
                    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
            end
            checkOutput("word_data", out_data, expWords[w]);
            checkOutput("word_sop", 64'(out_sop), 64'(w == 0));
            checkOutput("word_eop", 64'(out_eop), 64'(w == 2));
            @(negedge clk);
        end
        modelCount = modelCount + 16'd1;
        checkOutput("tx_count", 64'(tx_count), 64'(modelCount));
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic randomFrame(input bit holdValid, input bit allowStall);
        logic [15:0] s;
        logic [15:0] d;
        logic [63:0] p;
        int stallWord;
        int stallLen;
        s = 16'($urandom);
        d = 16'($urandom);
        p = {$urandom, $urandom};
        stallWord = allowStall ? int'($urandom_range(0, 3)) : 3;
        stallLen  = int'($urandom_range(1, 3));
        applyStimulus(s, d, p, holdValid);
        @(negedge clk);
        collectFrame(refWord(0, s, d, p), refWord(1, s, d, p), refWord(2, s, d, p), stallWord, stallLen);
    endtask

    initial begin
        int budget;
        int prevAccept;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        src_port   = '0;
        dst_port   = '0;
        in_payload = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_sop", 64'(out_sop), 64'd0);
        checkOutput("rst_out_eop", 64'(out_eop), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_tx_count", 64'(tx_count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic frame with header latency
        applyStimulus(16'h0000, 16'h0000, 64'h0123CDEFBCDEABCD, 1'b0);
        @(negedge clk);
        checkOutput("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("latency_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("latency_hdr", 64'(out_valid), 64'd1);
        collectFrame(64'h00000000000A0003, 64'h000000000040C7F3, 64'h0123CDEFBCDEABCD, -1, 0);

        // Zero checksum is sent as 0xFFFF
        applyStimulus(16'h0000, 16'h0000, 64'h000000000000FFB2, 1'b0);
        @(negedge clk);
        collectFrame(64'h00000000000A0003, 64'h000000000040FFFF, 64'h000000000000FFB2, -1, 0);

        // Carry folding
        applyStimulus(16'h0000, 16'h0000, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        @(negedge clk);
        collectFrame(64'h00000000000A0003, 64'h000000000040FFB2, 64'hFFFFFFFFFFFFFFFF, -1, 0);

        // Backpressure on the checksum word
        applyStimulus(16'h0000, 16'h0000, 64'h0123CDEFBCDEABCD, 1'b0);
        @(negedge clk);
        collectFrame(64'h00000000000A0003, 64'h000000000040C7F3, 64'h0123CDEFBCDEABCD, 1, 4);

        // Random frames with random stalls
        for (int i = 0; i < 20; i++) begin
            randomFrame(1'b0, 1'b1);
        end

        // Reset while the payload word is presented
        applyStimulus(16'($urandom), 16'($urandom), {$urandom, $urandom}, 1'b0);
        budget = 0;
        while (out_eop !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("reach_pay", 64'(out_eop), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        modelCount = 16'h0000;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_tx_count", 64'(tx_count), 64'(modelCount));
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        randomFrame(1'b0, 1'b0);

        // Back-to-back frames with in_valid held high
        prevAccept = 0;
        for (int i = 0; i < 30; i++) begin
            randomFrame(1'b1, 1'b0);
            if (i > 0) checkOutput("b2b_gap", 64'(acceptCycle - prevAccept), 64'd6);
            prevAccept = acceptCycle;
        end
        in_valid = 1'b0;

        // Counter wrap: preload near the top, then two back-to-back frames
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        modelCount = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            randomFrame(1'b1, 1'b0);
            if (i > 0) checkOutput("wrap_gap", 64'(acceptCycle - prevAccept), 64'd6);
            prevAccept = acceptCycle;
        end
        in_valid = 1'b0;
        checkOutput("wrap_zero", 64'(tx_count), 64'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
